// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: register indices, write-port count and
// the register-read stage state encoding.
package riscv_pkg;

   localparam int unsigned REGISTER_PORTS = 2;
   localparam int unsigned XLEN           = 32;
   localparam int unsigned REG_COUNT      = 32;
   localparam int unsigned IDX_W          = 6;
   localparam int unsigned SEL_W          = 5;

   typedef logic [IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      ISSUE = 2'd2
   } reg_read_state_e;

endpackage

// File: rtl/riscv_reg_fwd.sv
// Operand select for one source register: x0, snooped write-port forward or
// register file, plus the hazard flag that keeps the instruction held.
module riscv_reg_fwd
   import riscv_pkg::*;
#(
   parameter bit FORWARD = 1'b1
)
(
   input  reg_idx_t                             idx,
   input  logic [REG_COUNT-1:0][XLEN-1:0]       register,
   input  logic [REG_COUNT-1:0]                 register_locked,
   input  logic [REGISTER_PORTS-1:0]            register_write_en,
   input  reg_idx_t [REGISTER_PORTS-1:0]        register_write,
   input  logic [REGISTER_PORTS-1:0][XLEN-1:0]  register_write_data,
   output logic [XLEN-1:0]                      data_c,
   output logic                                 blocked_c
);

   logic            hit;
   logic [XLEN-1:0] fwd_data;

   // Ascending scan so the highest-numbered matching port wins.
   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      for (int unsigned n = 0; n < REGISTER_PORTS; n++) begin
         if (register_write_en[n] && (register_write[n] == idx)) begin
            hit      = 1'b1;
            fwd_data = register_write_data[n];
         end
      end
   end

   always_comb begin
      data_c = register[idx[SEL_W-1:0]];
      if (idx == '0) begin
         data_c = '0;
      end else if (FORWARD && hit) begin
         data_c = fwd_data;
      end
   end

   assign blocked_c = (idx != '0) && register_locked[idx[SEL_W-1:0]] && (!FORWARD || !hit);

endmodule

// File: rtl/riscv_reg_read.sv
// Register-read stage: captures a decoded instruction, waits out RAW/WAW
// hazards, locks rd in the register file and issues operands downstream.
module riscv_reg_read
   import riscv_pkg::*;
#(
   parameter bit FORWARD = 1'b1
)
(
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  reg_idx_t                             in_rs1,
   input  reg_idx_t                             in_rs2,
   input  reg_idx_t                             in_rd,
   input  logic                                 in_rd_en,
   input  logic [XLEN-1:0]                      in_tag,
   input  logic [REG_COUNT-1:0][XLEN-1:0]       register,
   input  logic [REG_COUNT-1:0]                 register_locked,
   input  logic [REGISTER_PORTS-1:0]            register_write_en,
   input  reg_idx_t [REGISTER_PORTS-1:0]        register_write,
   input  logic [REGISTER_PORTS-1:0][XLEN-1:0]  register_write_data,
   output logic                                 lock_en,
   output reg_idx_t                             lock,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [XLEN-1:0]                      out_rs1_data,
   output logic [XLEN-1:0]                      out_rs2_data,
   output reg_idx_t                             out_rd,
   output logic                                 out_rd_en,
   output logic [XLEN-1:0]                      out_tag
);

   reg_read_state_e state;
   reg_read_state_e next_state;

   reg_idx_t        cap_rs1;
   reg_idx_t        cap_rs2;
   reg_idx_t        cap_rd;
   logic            cap_rd_en;
   logic [XLEN-1:0] cap_tag;

   logic [XLEN-1:0] rs1_data_c;
   logic [XLEN-1:0] rs2_data_c;
   logic            rs1_blocked_c;
   logic            rs2_blocked_c;
   logic            rd_hit;
   logic            rd_blocked;
   logic            go;
   logic            accept;

   riscv_reg_fwd #(.FORWARD(FORWARD)) u_fwd_rs1 (
      .idx                 (cap_rs1),
      .register            (register),
      .register_locked     (register_locked),
      .register_write_en   (register_write_en),
      .register_write      (register_write),
      .register_write_data (register_write_data),
      .data_c              (rs1_data_c),
      .blocked_c           (rs1_blocked_c)
   );

   riscv_reg_fwd #(.FORWARD(FORWARD)) u_fwd_rs2 (
      .idx                 (cap_rs2),
      .register            (register),
      .register_locked     (register_locked),
      .register_write_en   (register_write_en),
      .register_write      (register_write),
      .register_write_data (register_write_data),
      .data_c              (rs2_data_c),
      .blocked_c           (rs2_blocked_c)
   );

   // A same-cycle write to rd retires the older writer, clearing the WAW hazard.
   always_comb begin
      rd_hit = 1'b0;
      for (int unsigned n = 0; n < REGISTER_PORTS; n++) begin
         if (register_write_en[n] && (register_write[n] == cap_rd)) begin
            rd_hit = 1'b1;
         end
      end
   end

   assign rd_blocked = cap_rd_en && (cap_rd != '0) && register_locked[cap_rd[SEL_W-1:0]] && !rd_hit;
   assign go         = (state == HOLD) && !rs1_blocked_c && !rs2_blocked_c && !rd_blocked;
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state == ISSUE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = HOLD;
         HOLD:    if (go) next_state = ISSUE;
         ISSUE:   if (out_ready) next_state = in_valid ? HOLD : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Reset masks handshake and lock so an in-flight instruction never locks rd.
   always_comb begin
      in_ready = 1'b0;
      lock_en  = 1'b0;
      lock     = '0;
      if (!reset) begin
         case (state)
            IDLE:  in_ready = 1'b1;
            ISSUE: in_ready = out_ready;
            HOLD: begin
               if (go && cap_rd_en && (cap_rd != '0)) begin
                  lock_en = 1'b1;
                  lock    = cap_rd;
               end
            end
            default: in_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cap_rs1      <= '0;
         cap_rs2      <= '0;
         cap_rd       <= '0;
         cap_rd_en    <= 1'b0;
         cap_tag      <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_rd       <= '0;
         out_rd_en    <= 1'b0;
         out_tag      <= '0;
      end else begin
         if (accept) begin
            cap_rs1   <= in_rs1;
            cap_rs2   <= in_rs2;
            cap_rd    <= in_rd;
            cap_rd_en <= in_rd_en;
            cap_tag   <= in_tag;
         end
         if (go) begin
            out_rs1_data <= rs1_data_c;
            out_rs2_data <= rs2_data_c;
            out_rd       <= cap_rd;
            out_rd_en    <= cap_rd_en;
            out_tag      <= cap_tag;
         end
      end
   end

endmodule

// File: doc/riscv_reg_read.md
RISCV_REG_READ -- requirements
Module: riscv_reg_read

Interface
REQ-001 SHALL have parameter FORWARD, default 1: 1 = operands taken from same-cycle register_write ports, 0 = wait for lock clear.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  decoded instruction present.
REQ-005 SHALL have port in_ready  output  1  block accepts instruction this cycle.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd  input  6 each  register indices; bit 5 always 0.
REQ-007 SHALL have port in_rd_en  input  1  instruction writes rd.
REQ-008 SHALL have port in_tag  input  32  opaque payload (PC), passed through.
REQ-009 SHALL have ports register [31:0][31:0] and register_locked 32, both input, from the register file.
REQ-010 SHALL have ports register_write_en REGISTER_PORTS, register_write REGISTER_PORTS x 6, register_write_data REGISTER_PORTS x 32, all input, snooped write ports.
REQ-011 SHALL have ports lock_en output 1 and lock output 6, driving one register-file lock port.
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1.
REQ-013 SHALL have outputs out_rs1_data 32, out_rs2_data 32, out_rd 6, out_rd_en 1, out_tag 32.

Function
REQ-014 SHALL implement states IDLE (empty), HOLD (captured, waiting on hazards), ISSUE (out_valid=1).
REQ-015 in_ready SHALL be 1 in IDLE, and in ISSUE when out_ready=1; 0 in HOLD.
REQ-016 in_valid&in_ready SHALL capture rs1/rs2/rd/rd_en/tag and move to HOLD.
REQ-017 In ISSUE, out_ready=1 with no new input SHALL move to IDLE; out_ready=1 with new input SHALL move to HOLD.
REQ-018 A source SHALL be blocked when its index is nonzero, its register_locked bit is 1, and (FORWARD=0 or no register_write_en[n] targets it this cycle).
REQ-019 rd SHALL be blocked (WAW) when rd_en=1, rd nonzero, locked, and not written this cycle.
REQ-020 In HOLD with no source or rd blocked: latch operands, pulse lock_en=1 with lock=rd for exactly that cycle (only if rd_en=1 and rd!=0), move to ISSUE.
REQ-021 Operand select SHALL be: index 0 -> 0; else the highest-numbered matching write port when FORWARD=1; else register[idx].
REQ-022 Without hazards, out_valid SHALL rise 2 cycles after the accepting cycle.
REQ-023 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 lock_en SHALL be 0 in IDLE and ISSUE; at most one lock pulse per accepted instruction.
REQ-025 rs1==rs2 and rs==rd SHALL need no special-case handling; rd's own lock never blocks its sources.

Reset
REQ-026 Reset SHALL force IDLE, out_valid=0, lock_en=0, lock=0, all data, tag and rd outputs 0, overriding any in-flight instruction with no lock pulse.
REQ-027 Reset SHALL win over simultaneous in_valid; in_ready SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-028 riscv_pkg SHALL hold REGISTER_PORTS (existing), typedef reg_idx_t (6-bit), and enum reg_read_state_e.
REQ-029 Operand select SHALL be a combinational sub-module riscv_reg_fwd, instantiated once per source.

Verification
REQ-030 No hazard: rs1=1 (0x11), rs2=2 (0x22), rd=3 -> lock_en=1/lock=3 at N+1; out_valid at N+2 with 0x11/0x22.
REQ-031 Locked source: x5 locked, write x5=0xABCD at cycle N+4 -> FORWARD=1: issue at N+5 with 0xABCD; FORWARD=0: issue at N+6.
REQ-032 Dual write to x7 (port0=0x1, port1=0x2) same cycle, x7 locked, FORWARD=1 -> operand 0x2.
REQ-033 x0: rs1=0, register[0]=0xFFFF_FFFF garbage, locked[0]=1 -> operand 0, no stall; rd=0 -> no lock pulse.
REQ-034 Backpressure: out_ready=0 for 5 cycles -> outputs constant, in_ready=0; out_ready=1 plus in_valid -> back-to-back capture.
REQ-035 Reset in HOLD and in ISSUE -> next cycle IDLE, out_valid=0, no lock_en pulse.
